// File: rtl/dcache_ctrl_fsm.sv
// Data-cache controller FSM: sequences lookup, write-back, refill,
// uncached access and cache-maintenance (cacop) operations for a
// WAYS-way set-associative cache with LINE_WORDS-word lines.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   valid_i, cacop_en_i   new load/store request, new cacop request
//   op_i .. size_i        attributes of the buffered request
//   exception_i           lookup-stage exception for the buffered request
//   hit_i, victim_way_i, cacop_way_i, victim_dirty_i, cacop_code_i
//                         tag-compare / replacement / cacop inputs
//   r_*_i, w_*_i          read and write bus handshakes
//   cache_ready_o .. cacop_done_o   pipeline handshakes
//   r_req_o, r_data_ready_o, w_req_o, r_len_o, w_len_o, r_size_o, w_size_o
//                         bus requests and burst shape
//   way_sel_o, data_we_o, tagv_we_o, dirty_we_o, tagv_clear_o, dirty_wdata_o,
//   wbuf_we_o, llbit_set_o, llbit_clear_o, beat_idx_o
//                         array, buffer and LLbit controls
module dcache_ctrl_fsm #(
  parameter int unsigned WAYS       = 4,
  parameter int unsigned LINE_WORDS = 16,
  parameter int unsigned CNT_W      = $clog2(LINE_WORDS)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic              cacop_en_i,
  input  logic              op_i,
  input  logic              uncache_i,
  input  logic              is_atom_i,
  input  logic              llbit_i,
  input  logic [1:0]        size_i,
  input  logic              exception_i,
  input  logic [WAYS-1:0]   hit_i,
  input  logic [WAYS-1:0]   victim_way_i,
  input  logic [WAYS-1:0]   cacop_way_i,
  input  logic              victim_dirty_i,
  input  logic [1:0]        cacop_code_i,
  input  logic              r_rdy_i,
  input  logic              r_valid_i,
  input  logic              r_last_i,
  input  logic              w_rdy_i,
  input  logic              w_done_i,
  output logic              cache_ready_o,
  output logic              rbuf_we_o,
  output logic              data_valid_o,
  output logic              cacop_done_o,
  output logic              r_req_o,
  output logic              r_data_ready_o,
  output logic              w_req_o,
  output logic [7:0]        r_len_o,
  output logic [7:0]        w_len_o,
  output logic [2:0]        r_size_o,
  output logic [2:0]        w_size_o,
  output logic [WAYS-1:0]   way_sel_o,
  output logic [WAYS-1:0]   data_we_o,
  output logic [WAYS-1:0]   tagv_we_o,
  output logic [WAYS-1:0]   dirty_we_o,
  output logic              tagv_clear_o,
  output logic              dirty_wdata_o,
  output logic              wbuf_we_o,
  output logic              llbit_set_o,
  output logic              llbit_clear_o,
  output logic [CNT_W-1:0]  beat_idx_o
);

  localparam int unsigned LEN_W  = 8;
  localparam int unsigned SIZE_W = 3;

  typedef enum logic [9:0] {
    S_IDLE    = 10'b00_0000_0001,
    S_LOOKUP  = 10'b00_0000_0010,
    S_CACOP   = 10'b00_0000_0100,
    S_WB_REQ  = 10'b00_0000_1000,
    S_WB_WAIT = 10'b00_0001_0000,
    S_RD_REQ  = 10'b00_0010_0000,
    S_REFILL  = 10'b00_0100_0000,
    S_WR_REQ  = 10'b00_1000_0000,
    S_WR_WAIT = 10'b01_0000_0000,
    S_DONE    = 10'b10_0000_0000
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  beat_q, beat_d;
  logic              cacop_q, cacop_d;   // buffered request is a cacop
  logic              op_q, op_d;
  logic              unc_q, unc_d;
  logic [1:0]        size_q, size_d;

  logic              new_req;
  logic              sc_fail;
  logic              hit_path;
  logic [WAYS-1:0]   cacop_tgt;

  assign new_req  = valid_i | cacop_en_i;
  assign sc_fail  = is_atom_i & op_i & ~llbit_i;
  assign hit_path = ~uncache_i & (|hit_i);

  // Index cacops address cacop_way, hit-invalidate uses the tag compare, code 3 is a no-op
  assign cacop_tgt = (cacop_code_i == 2'd2) ? hit_i :
                     (cacop_code_i == 2'd3) ? '0    : cacop_way_i;

  // Burst shape follows the attributes captured when the request left LOOKUP
  assign r_len_o    = unc_q ? '0 : LEN_W'(LINE_WORDS - 1);
  assign w_len_o    = unc_q ? '0 : LEN_W'(LINE_WORDS - 1);
  assign r_size_o   = unc_q ? {1'b0, size_q} : SIZE_W'(2);
  assign w_size_o   = unc_q ? {1'b0, size_q} : SIZE_W'(2);
  assign beat_idx_o = beat_q;

  // State and context registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      cacop_q <= 1'b0;
      op_q    <= 1'b0;
      unc_q   <= 1'b0;
      size_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      cacop_q <= cacop_d;
      op_q    <= op_d;
      unc_q   <= unc_d;
      size_q  <= size_d;
    end
  end

  // Next-state and control outputs
  always_comb begin
    state_d        = state_q;
    beat_d         = beat_q;
    cacop_d        = cacop_q;
    op_d           = op_q;
    unc_d          = unc_q;
    size_d         = size_q;
    cache_ready_o  = 1'b0;
    rbuf_we_o      = 1'b0;
    data_valid_o   = 1'b0;
    cacop_done_o   = 1'b0;
    r_req_o        = 1'b0;
    r_data_ready_o = 1'b0;
    w_req_o        = 1'b0;
    way_sel_o      = '0;
    data_we_o      = '0;
    tagv_we_o      = '0;
    dirty_we_o     = '0;
    tagv_clear_o   = 1'b0;
    dirty_wdata_o  = 1'b0;
    wbuf_we_o      = 1'b0;
    llbit_set_o    = 1'b0;
    llbit_clear_o  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cache_ready_o = 1'b1;
        if (new_req) begin
          rbuf_we_o = 1'b1;
          cacop_d   = cacop_en_i;
          state_d   = S_LOOKUP;
        end
      end

      S_LOOKUP: begin
        op_d   = op_i;
        unc_d  = uncache_i & ~cacop_q;
        size_d = size_i;
        if (exception_i) begin
          data_valid_o = 1'b1;
          state_d      = S_IDLE;
        end else if (cacop_q) begin
          state_d = S_CACOP;
        end else begin
          llbit_set_o   = is_atom_i & ~op_i;
          llbit_clear_o = is_atom_i & op_i & llbit_i;
          if (sc_fail || hit_path) begin
            // Completes in this cycle; a failed SC only reports back
            data_valid_o  = 1'b1;
            cache_ready_o = 1'b1;
            if (hit_path) way_sel_o = hit_i;
            if (hit_path && op_i && !sc_fail) begin
              data_we_o     = hit_i;
              dirty_we_o    = hit_i;
              dirty_wdata_o = 1'b1;
            end
            if (new_req) begin
              rbuf_we_o = 1'b1;
              cacop_d   = cacop_en_i;
            end else begin
              state_d = S_IDLE;
            end
          end else if (uncache_i) begin
            wbuf_we_o = op_i;
            state_d   = op_i ? S_WR_REQ : S_RD_REQ;
          end else begin
            wbuf_we_o = 1'b1;
            state_d   = victim_dirty_i ? S_WB_REQ : S_RD_REQ;
          end
        end
      end

      S_CACOP: begin
        state_d = S_DONE;
        if (|cacop_tgt) begin
          tagv_we_o    = cacop_tgt;
          dirty_we_o   = cacop_tgt;
          tagv_clear_o = 1'b1;
          // Store-tag (code 0) never writes back
          if (cacop_code_i != 2'd0 && victim_dirty_i) begin
            wbuf_we_o = 1'b1;
            state_d   = S_WB_REQ;
          end
        end
      end

      S_WB_REQ: begin
        w_req_o = 1'b1;
        if (w_rdy_i) state_d = S_WB_WAIT;
      end

      S_WB_WAIT: begin
        if (w_done_i) state_d = cacop_q ? S_DONE : S_RD_REQ;
      end

      S_RD_REQ: begin
        r_req_o = 1'b1;
        if (r_rdy_i) begin
          beat_d  = '0;
          state_d = S_REFILL;
        end
      end

      S_REFILL: begin
        r_data_ready_o = 1'b1;
        if (r_valid_i) begin
          beat_d = beat_q + CNT_W'(1);
          if (r_last_i) begin
            state_d = S_DONE;
            if (!unc_q) begin
              way_sel_o     = victim_way_i;
              data_we_o     = victim_way_i;
              tagv_we_o     = victim_way_i;
              dirty_we_o    = victim_way_i;
              dirty_wdata_o = op_q;
            end
          end
        end
      end

      S_WR_REQ: begin
        w_req_o = 1'b1;
        if (w_rdy_i) state_d = S_WR_WAIT;
      end

      S_WR_WAIT: begin
        if (w_done_i) state_d = S_DONE;
      end

      S_DONE: begin
        cache_ready_o = 1'b1;
        cacop_done_o  = cacop_q;
        data_valid_o  = ~cacop_q;
        if (new_req) begin
          rbuf_we_o = 1'b1;
          cacop_d   = cacop_en_i;
          state_d   = S_LOOKUP;
        end else begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dcache_ctrl_fsm.sv
// Testbench for dcache_ctrl_fsm: two instances (4-way/16-word and
// 8-way/4-word) share one stimulus stream; the selected instance is checked
// every cycle against expectations derived per transaction.
module tb_dcache_ctrl_fsm;

  localparam int unsigned WA = 4;
  localparam int unsigned LA = 16;
  localparam int unsigned WB = 8;
  localparam int unsigned LB = 4;

  typedef struct packed {
    logic       cache_ready, rbuf_we, data_valid, cacop_done, r_req, r_data_ready, w_req;
    logic [7:0] r_len, w_len;
    logic [2:0] r_size, w_size;
    logic [7:0] way_sel, data_we, tagv_we, dirty_we;
    logic       tagv_clear, dirty_wdata, wbuf_we, llbit_set, llbit_clear;
    logic [7:0] beat_idx;
  } outs_t;

  typedef struct packed {
    logic       op, unc, atom, llb, exc, vdirty;
    logic [1:0] size;
    logic [7:0] hit, vway;
  } req_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, valid, cacop_en, op, uncache, is_atom, llbit, exception, victim_dirty;
  logic [1:0] size, cacop_code;
  logic [7:0] hit, victim_way, cacop_way;
  logic       r_rdy, r_valid, r_last, w_rdy, w_done;

  logic a_cache_ready, a_rbuf_we, a_data_valid, a_cacop_done, a_r_req, a_r_data_ready, a_w_req;
  logic [7:0] a_r_len, a_w_len;
  logic [2:0] a_r_size, a_w_size;
  logic [WA-1:0] a_way_sel, a_data_we, a_tagv_we, a_dirty_we;
  logic a_tagv_clear, a_dirty_wdata, a_wbuf_we, a_llbit_set, a_llbit_clear;
  logic [$clog2(LA)-1:0] a_beat_idx;

  logic b_cache_ready, b_rbuf_we, b_data_valid, b_cacop_done, b_r_req, b_r_data_ready, b_w_req;
  logic [7:0] b_r_len, b_w_len;
  logic [2:0] b_r_size, b_w_size;
  logic [WB-1:0] b_way_sel, b_data_we, b_tagv_we, b_dirty_we;
  logic b_tagv_clear, b_dirty_wdata, b_wbuf_we, b_llbit_set, b_llbit_clear;
  logic [$clog2(LB)-1:0] b_beat_idx;

  dcache_ctrl_fsm #(.WAYS(WA), .LINE_WORDS(LA)) u_a (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .cacop_en_i(cacop_en), .op_i(op),
    .uncache_i(uncache), .is_atom_i(is_atom), .llbit_i(llbit), .size_i(size),
    .exception_i(exception), .hit_i(hit[WA-1:0]), .victim_way_i(victim_way[WA-1:0]),
    .cacop_way_i(cacop_way[WA-1:0]), .victim_dirty_i(victim_dirty), .cacop_code_i(cacop_code),
    .r_rdy_i(r_rdy), .r_valid_i(r_valid), .r_last_i(r_last), .w_rdy_i(w_rdy), .w_done_i(w_done),
    .cache_ready_o(a_cache_ready), .rbuf_we_o(a_rbuf_we), .data_valid_o(a_data_valid),
    .cacop_done_o(a_cacop_done), .r_req_o(a_r_req), .r_data_ready_o(a_r_data_ready),
    .w_req_o(a_w_req), .r_len_o(a_r_len), .w_len_o(a_w_len), .r_size_o(a_r_size),
    .w_size_o(a_w_size), .way_sel_o(a_way_sel), .data_we_o(a_data_we), .tagv_we_o(a_tagv_we),
    .dirty_we_o(a_dirty_we), .tagv_clear_o(a_tagv_clear), .dirty_wdata_o(a_dirty_wdata),
    .wbuf_we_o(a_wbuf_we), .llbit_set_o(a_llbit_set), .llbit_clear_o(a_llbit_clear),
    .beat_idx_o(a_beat_idx)
  );

  dcache_ctrl_fsm #(.WAYS(WB), .LINE_WORDS(LB)) u_b (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .cacop_en_i(cacop_en), .op_i(op),
    .uncache_i(uncache), .is_atom_i(is_atom), .llbit_i(llbit), .size_i(size),
    .exception_i(exception), .hit_i(hit), .victim_way_i(victim_way),
    .cacop_way_i(cacop_way), .victim_dirty_i(victim_dirty), .cacop_code_i(cacop_code),
    .r_rdy_i(r_rdy), .r_valid_i(r_valid), .r_last_i(r_last), .w_rdy_i(w_rdy), .w_done_i(w_done),
    .cache_ready_o(b_cache_ready), .rbuf_we_o(b_rbuf_we), .data_valid_o(b_data_valid),
    .cacop_done_o(b_cacop_done), .r_req_o(b_r_req), .r_data_ready_o(b_r_data_ready),
    .w_req_o(b_w_req), .r_len_o(b_r_len), .w_len_o(b_w_len), .r_size_o(b_r_size),
    .w_size_o(b_w_size), .way_sel_o(b_way_sel), .data_we_o(b_data_we), .tagv_we_o(b_tagv_we),
    .dirty_we_o(b_dirty_we), .tagv_clear_o(b_tagv_clear), .dirty_wdata_o(b_dirty_wdata),
    .wbuf_we_o(b_wbuf_we), .llbit_set_o(b_llbit_set), .llbit_clear_o(b_llbit_clear),
    .beat_idx_o(b_beat_idx)
  );

  bit    sel;
  int    ways, lw;
  int    passed = 0, failed = 0, total = 0;
  outs_t obs;

  // Observed outputs of the instance under check, widened to 8-bit fields
  always_comb begin
    obs = '0;
    if (!sel) begin
      obs.cache_ready = a_cache_ready; obs.rbuf_we = a_rbuf_we; obs.data_valid = a_data_valid;
      obs.cacop_done = a_cacop_done; obs.r_req = a_r_req; obs.r_data_ready = a_r_data_ready;
      obs.w_req = a_w_req; obs.r_len = a_r_len; obs.w_len = a_w_len;
      obs.r_size = a_r_size; obs.w_size = a_w_size; obs.way_sel = 8'(a_way_sel);
      obs.data_we = 8'(a_data_we); obs.tagv_we = 8'(a_tagv_we); obs.dirty_we = 8'(a_dirty_we);
      obs.tagv_clear = a_tagv_clear; obs.dirty_wdata = a_dirty_wdata; obs.wbuf_we = a_wbuf_we;
      obs.llbit_set = a_llbit_set; obs.llbit_clear = a_llbit_clear; obs.beat_idx = 8'(a_beat_idx);
    end else begin
      obs.cache_ready = b_cache_ready; obs.rbuf_we = b_rbuf_we; obs.data_valid = b_data_valid;
      obs.cacop_done = b_cacop_done; obs.r_req = b_r_req; obs.r_data_ready = b_r_data_ready;
      obs.w_req = b_w_req; obs.r_len = b_r_len; obs.w_len = b_w_len;
      obs.r_size = b_r_size; obs.w_size = b_w_size; obs.way_sel = 8'(b_way_sel);
      obs.data_we = 8'(b_data_we); obs.tagv_we = 8'(b_tagv_we); obs.dirty_we = 8'(b_dirty_we);
      obs.tagv_clear = b_tagv_clear; obs.dirty_wdata = b_dirty_wdata; obs.wbuf_we = b_wbuf_we;
      obs.llbit_set = b_llbit_set; obs.llbit_clear = b_llbit_clear; obs.beat_idx = 8'(b_beat_idx);
    end
  end

  function automatic logic [7:0] rand_oh();
    logic [7:0] v;
    v = '0;
    v[$urandom_range(ways - 1, 0)] = 1'b1;
    return v;
  endfunction

  // All-quiet outputs with the burst shape of a cached or uncached access
  function automatic outs_t base(input logic unc, input logic [1:0] sz);
    outs_t e;
    e = '0;
    e.r_len  = unc ? 8'd0 : 8'(lw - 1);
    e.w_len  = e.r_len;
    e.r_size = unc ? {1'b0, sz} : 3'b010;
    e.w_size = e.r_size;
    return e;
  endfunction

  // Compare mid-cycle, then advance to the next falling edge
  task automatic cyc(input outs_t e, input string tag, input bit mlen, input bit mbeat);
    outs_t o, x;
    #1;
    o = obs;
    x = e;
    if (mlen) begin
      o.r_len = '0; o.w_len = '0; o.r_size = '0; o.w_size = '0;
      x.r_len = '0; x.w_len = '0; x.r_size = '0; x.w_size = '0;
    end
    if (mbeat) begin
      o.beat_idx = '0;
      x.beat_idx = '0;
    end
    total++;
    assert (o === x) passed++;
    else begin
      failed++;
      $error("FAIL %s (inst %0d): observed %h expected %h", tag, sel, o, x);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    valid = 0; cacop_en = 0; op = 0; uncache = 0; is_atom = 0; llbit = 0; size = 0;
    exception = 0; hit = 0; victim_way = 0; cacop_way = 0; victim_dirty = 0; cacop_code = 0;
    r_rdy = 0; r_valid = 0; r_last = 0; w_rdy = 0; w_done = 0;
  endtask

  task automatic drive_req(input req_t r);
    op = r.op; uncache = r.unc; is_atom = r.atom; llbit = r.llb; exception = r.exc;
    victim_dirty = r.vdirty; size = r.size; hit = r.hit; victim_way = r.vway;
  endtask

  task automatic accept(input bit cac);
    outs_t e;
    e = base(0, 0);
    e.cache_ready = 1;
    e.rbuf_we = 1;
    if (cac) cacop_en = 1; else valid = 1;
    cyc(e, "idle_accept", 1, 1);
    valid = 0;
    cacop_en = 0;
  endtask

  // Write-address handshake then response; w_done alongside w_rdy must be ignored
  task automatic write_phase(input logic unc, input logic [1:0] sz);
    outs_t e;
    int d;
    e = base(unc, sz);
    e.w_req = 1;
    d = $urandom_range(2, 0);
    repeat (d) cyc(e, "w_req_wait", 0, 1);
    w_rdy = 1;
    w_done = 1'($urandom_range(1, 0));
    cyc(e, "w_req_accept", 0, 1);
    w_rdy = 0;
    w_done = 0;
    e.w_req = 0;
    d = $urandom_range(2, 0);
    repeat (d) cyc(e, "w_wait", 0, 1);
    w_done = 1;
    cyc(e, "w_done", 0, 1);
    w_done = 0;
  endtask

  task automatic read_phase(input logic unc, input logic wr, input logic [1:0] sz,
                            input logic [7:0] vway);
    outs_t e;
    int d, n, k;
    e = base(unc, sz);
    e.r_req = 1;
    d = $urandom_range(2, 0);
    repeat (d) cyc(e, "r_req_wait", 0, 1);
    r_rdy = 1;
    cyc(e, "r_req_accept", 0, 1);
    r_rdy = 0;
    e.r_req = 0;
    e.r_data_ready = 1;
    n = unc ? 1 : lw;
    k = 0;
    for (int i = 0; i < n; i++) begin
      e.beat_idx = 8'(k);
      r_valid = 0;
      d = $urandom_range(1, 0);
      repeat (d) cyc(e, "refill_gap", 0, 0);
      r_valid = 1;
      r_last = (i == n - 1);
      if (i == n - 1 && !unc) begin
        e.way_sel = vway; e.data_we = vway; e.tagv_we = vway; e.dirty_we = vway;
        e.dirty_wdata = wr;
      end
      cyc(e, "refill_beat", 0, 0);
      k = (k + 1) % lw;
    end
    r_valid = 0;
    r_last = 0;
  endtask

  task automatic done_phase(input bit cac, input bit nxt, output bit again);
    outs_t e;
    e = base(0, 0);
    e.cache_ready = 1;
    if (cac) e.cacop_done = 1; else e.data_valid = 1;
    if (nxt) begin
      valid = 1;
      e.rbuf_we = 1;
    end
    cyc(e, "done", 1, 1);
    valid = 0;
    again = nxt;
  endtask

  // One load/store from LOOKUP to completion
  task automatic do_lookup(input req_t r, input bit nxt, output bit again);
    outs_t e;
    logic scf, hitc;
    drive_req(r);
    valid = 0;
    again = 0;
    e = base(0, 0);
    if (r.exc) begin
      e.data_valid = 1;
      cyc(e, "lookup_exc", 1, 1);
      exception = 0;
      return;
    end
    scf  = r.atom & r.op & ~r.llb;
    hitc = ~r.unc & (r.hit != 0);
    e.llbit_set   = r.atom & ~r.op;
    e.llbit_clear = r.atom & r.op & r.llb;
    if (scf || hitc) begin
      e.data_valid = 1;
      e.cache_ready = 1;
      if (hitc) e.way_sel = r.hit;
      if (hitc && r.op && !scf) begin
        e.data_we = r.hit; e.dirty_we = r.hit; e.dirty_wdata = 1;
      end
      if (nxt) begin
        valid = 1;
        e.rbuf_we = 1;
      end
      cyc(e, "lookup_hit", 1, 1);
      valid = 0;
      again = nxt;
      return;
    end
    e.wbuf_we = ~(r.unc & ~r.op);
    cyc(e, "lookup_miss", 1, 1);
    if (r.unc) begin
      if (r.op) write_phase(1, r.size);
      else read_phase(1, r.op, r.size, r.vway);
    end else begin
      if (r.vdirty) write_phase(0, r.size);
      read_phase(0, r.op, r.size, r.vway);
    end
    done_phase(0, nxt, again);
  endtask

  task automatic ls_txn(input req_t r, input bit nxt);
    bit again;
    accept(0);
    do_lookup(r, nxt, again);
    while (again) do_lookup(rand_req(), ($urandom_range(2, 0) == 0), again);
  endtask

  task automatic do_cacop(input logic [1:0] code, input logic [7:0] cway, input logic [7:0] h,
                          input bit vd, input bit exc);
    outs_t e;
    logic [7:0] tgt;
    bit wb, again;
    accept(1);
    idle_inputs();
    uncache = 1'($urandom_range(1, 0));
    exception = exc;
    e = base(0, 0);
    if (exc) begin
      e.data_valid = 1;
      cyc(e, "cacop_exc", 1, 1);
      exception = 0;
      return;
    end
    cyc(e, "cacop_lookup", 1, 1);
    cacop_code = code; cacop_way = cway; hit = h; victim_dirty = vd;
    tgt = (code == 2) ? h : ((code == 3) ? 8'd0 : cway);
    if (tgt != 0) begin
      e.tagv_we = tgt; e.dirty_we = tgt; e.tagv_clear = 1;
    end
    wb = (code == 1 || code == 2) && tgt != 0 && vd;
    e.wbuf_we = wb;
    cyc(e, "cacop", 1, 1);
    if (wb) write_phase(0, 0);
    done_phase(1, 0, again);
  endtask

  function automatic req_t rand_req();
    req_t r;
    r.op     = 1'($urandom_range(1, 0));
    r.unc    = ($urandom_range(2, 0) == 0);
    r.atom   = ($urandom_range(3, 0) == 0);
    r.llb    = 1'($urandom_range(1, 0));
    r.exc    = ($urandom_range(7, 0) == 0);
    r.vdirty = 1'($urandom_range(1, 0));
    r.size   = 2'($urandom_range(2, 0));
    r.hit    = ($urandom_range(1, 0) == 1) ? rand_oh() : 8'd0;
    r.vway   = rand_oh();
    return r;
  endfunction

  // Reset lands in the middle of a refill burst
  task automatic reset_mid_burst();
    req_t r;
    outs_t e;
    accept(0);
    r = '0;
    r.vway = rand_oh();
    drive_req(r);
    e = base(0, 0);
    e.wbuf_we = 1;
    cyc(e, "rst_lookup", 1, 1);
    e = base(0, 0);
    e.r_req = 1;
    r_rdy = 1;
    cyc(e, "rst_r_req", 0, 1);
    r_rdy = 0;
    e.r_req = 0;
    e.r_data_ready = 1;
    r_valid = 1;
    for (int i = 0; i < 7; i++) begin
      e.beat_idx = 8'(i % lw);
      cyc(e, "rst_refill", 0, 0);
    end
    rst = 1;
    e.beat_idx = 8'(7 % lw);
    cyc(e, "rst_beat7", 0, 0);
    rst = 0;
    idle_inputs();
    e = base(0, 0);
    e.cache_ready = 1;
    cyc(e, "rst_recover", 0, 0);
  endtask

  task automatic run_phase();
    outs_t e;
    req_t r;
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    e = base(0, 0);
    e.cache_ready = 1;
    cyc(e, "reset_state", 0, 0);
    cyc(e, "idle_quiet", 0, 0);

    r = '0; r.hit = 8'b0000_0100; r.vway = 8'b0000_0001;
    ls_txn(r, 0);                                              // cached read hit
    r = '0; r.vdirty = 1; r.vway = 8'b0000_0010;
    ls_txn(r, 0);                                              // dirty miss
    r = '0; r.op = 1; r.unc = 1; r.size = 2'd1; r.vway = 8'b0000_0001;
    ls_txn(r, 0);                                              // uncached half write
    r = '0; r.op = 1; r.atom = 1; r.hit = 8'b0000_0010; r.vway = 8'b0000_0001;
    ls_txn(r, 1);                                              // failed SC on hit
    do_cacop(2'd1, 8'b0000_1000, 8'd0, 1, 0);
    do_cacop(2'd0, 8'b0000_0001, 8'd0, 1, 0);
    do_cacop(2'd2, 8'b0000_0001, 8'd0, 1, 0);
    do_cacop(2'd3, 8'b0000_0010, 8'b0000_0010, 1, 0);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(3, 0) == 0)
        do_cacop(2'($urandom_range(3, 0)), rand_oh(),
                 ($urandom_range(1, 0) == 1) ? rand_oh() : 8'd0,
                 1'($urandom_range(1, 0)), ($urandom_range(7, 0) == 0));
      else
        ls_txn(rand_req(), ($urandom_range(2, 0) == 0));
    end

    reset_mid_burst();
    r = '0; r.vway = rand_oh();
    ls_txn(r, 0);
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    sel = 0; ways = WA; lw = LA;
    run_phase();
    sel = 1; ways = WB; lw = LB;
    run_phase();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
